// File: rtl/seq_divider.sv
// Multi-cycle non-restoring signed divider (Y / bus -> ZLO quotient, ZHI remainder).
// Define SEQ_DIVIDER_UNSIGNED_EN to add the unsigned_i mode select, sampled with start_i.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             unsigned_i,
`endif
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;        // signed partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend magnitude shifting into quotient bits
  logic [WIDTH-1:0] d_q, d_d;        // divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic             is_unsigned_c;
  logic [WIDTH:0]   p_shift_c, p_new_c;
  logic [WIDTH-1:0] rem_mag_c;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign is_unsigned_c = unsigned_i;
`else
  assign is_unsigned_c = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    p_shift_c = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    p_new_c   = p_shift_c;
    rem_mag_c = p_q[WIDTH-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sign_a_d = ~is_unsigned_c & dividend_i[WIDTH-1];
          sign_b_d = ~is_unsigned_c & divisor_i[WIDTH-1];
          q_d      = sign_a_d ? neg(dividend_i) : dividend_i;
          d_d      = sign_b_d ? neg(divisor_i) : divisor_i;
          p_d      = '0;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          dz_d     = (divisor_i == '0);
          state_d  = dz_d ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        p_new_c = p_q[WIDTH] ? p_shift_c + {1'b0, d_q} : p_shift_c - {1'b0, d_q};
        p_d     = p_new_c;
        q_d     = {q_q[WIDTH-2:0], ~p_new_c[WIDTH]};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          quot_d = '1;
          rem_d  = sign_a_q ? neg(q_q) : q_q;
        end else begin
          // final restore: the true remainder always fits in WIDTH bits
          rem_mag_c = p_q[WIDTH] ? p_q[WIDTH-1:0] + d_q : p_q[WIDTH-1:0];
          quot_d    = (sign_a_q ^ sign_b_q) ? neg(q_q) : q_q;
          rem_d     = sign_a_q ? neg(rem_mag_c) : rem_mag_c;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      q_q      <= q_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign div_zero_o  = dz_q;

endmodule
